// File: rtl/conv_output_collector_if.sv
// ---------------------------------------------------------------------------
// conv_output_collector_if
//   Output stream of the convolution result collector: one rescaled sample
//   per transfer, tagged with its output-feature-map address.
//
//   Handshake: a transfer happens on a rising clk edge where out_valid and
//   out_ready are both 1. While out_valid is 1 and out_ready is 0, the master
//   holds out_data, out_addr and out_last stable. The master never withdraws
//   out_valid before the transfer completes.
//
//   Signals:
//     out_valid  master -> slave  head entry present
//     out_ready  slave  -> master slave accepts the head this cycle
//     out_data   master -> slave  rescaled signed sample (DATA_WIDTH)
//     out_addr   master -> slave  row*OUT_DIM+col of the sample (ADDR_W)
//     out_last   master -> slave  sample is the last pixel of the frame
// ---------------------------------------------------------------------------
interface conv_output_collector_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_W     = 10
) ();
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [ADDR_W-1:0]     out_addr;
    logic                  out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_addr,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_addr,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/conv_output_collector.sv
// ---------------------------------------------------------------------------
// conv_output_collector
//   Receives the convolver's enable-qualified accumulator stream, rescales
//   each result (arithmetic shift right by FRAC_BITS, saturate to DATA_WIDTH),
//   tags it with its row-major output address and queues it in a small FIFO
//   for a ready/valid writer. After OUT_DIM*OUT_DIM beats the frame drains
//   and frame_done pulses for one cycle.
//
//   Optional feature: define CONV_RELU_EN to clamp negative results to 0
//   before saturation. Timing and interface are the same either way.
//
//   Ports:
//     clk             rising-edge clock
//     rst             synchronous active-high reset
//     start           begin a frame (only honoured in IDLE)
//     in_valid        accumulator result valid
//     in_data         signed accumulator result (ACC_WIDTH)
//     out_if          output stream (master modport), see interface header
//     busy            state is not IDLE
//     frame_done      one-cycle pulse at frame end
//     overflow        sticky: a result was dropped on a full FIFO
//     protocol_error  sticky: in_valid seen outside RUN
//     state_o         current FSM state (debug)
// ---------------------------------------------------------------------------
module conv_output_collector #(
    parameter int DATA_WIDTH  = 16,
    parameter int ACC_WIDTH   = 40,
    parameter int FRAC_BITS   = 8,
    parameter int IMAGE_SIZE  = 28,
    parameter int KERNEL_SIZE = 5,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        in_valid,
    input  logic signed [ACC_WIDTH-1:0] in_data,
    conv_output_collector_if.master     out_if,
    output logic                        busy,
    output logic                        frame_done,
    output logic                        overflow,
    output logic                        protocol_error,
    output logic [1:0]                  state_o
);
    localparam int OUT_DIM = IMAGE_SIZE - KERNEL_SIZE + 1;
    localparam int NPIX    = OUT_DIM * OUT_DIM;
    localparam int ADDR_W  = $clog2(NPIX);
    localparam int PTR_W   = $clog2(FIFO_DEPTH) + 1;  // extra bit tells full from empty
    localparam int ENTRY_W = 1 + ADDR_W + DATA_WIDTH;

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic [ADDR_W-1:0]     addr_cnt_q, addr_cnt_d;
    logic                  overflow_q, overflow_d;
    logic                  protocol_error_q, protocol_error_d;
    logic                  stg_valid_q, stg_valid_d;
    logic [DATA_WIDTH-1:0] stg_data_q, stg_data_d;
    logic [ADDR_W-1:0]     stg_addr_q, stg_addr_d;
    logic                  stg_last_q, stg_last_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [ENTRY_W-1:0]    mem_q [FIFO_DEPTH];

    logic                  capture, start_accept, last_beat;
    logic [PTR_W-1:0]      fifo_count;
    logic                  fifo_empty, fifo_full, push, pop, drop;
    logic signed [ACC_WIDTH-1:0] shifted, clipped;
    logic [DATA_WIDTH-1:0] scaled;

    assign capture      = in_valid && (state_q == S_RUN);
    assign start_accept = start && (state_q == S_IDLE);
    assign last_beat    = (addr_cnt_q == ADDR_W'(NPIX - 1));

    // Rescale: floor shift, optional ReLU, then clamp into the output range.
    always_comb begin
        shifted = in_data >>> FRAC_BITS;
`ifdef CONV_RELU_EN
        clipped = shifted[ACC_WIDTH-1] ? '0 : shifted;
`else
        clipped = shifted;
`endif
        if (clipped > SAT_MAX) begin
            scaled = SAT_MAX[DATA_WIDTH-1:0];
        end else if (clipped < SAT_MIN) begin
            scaled = SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            scaled = clipped[DATA_WIDTH-1:0];
        end
    end

    // FIFO bookkeeping. A pop in the same cycle frees a slot, so a push into
    // a full FIFO still succeeds when the head leaves simultaneously.
    assign fifo_count = wr_ptr_q - rd_ptr_q;
    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == PTR_W'(FIFO_DEPTH));
    assign pop        = out_if.out_valid && out_if.out_ready;
    assign push       = stg_valid_q && (!fifo_full || pop);
    assign drop       = stg_valid_q && fifo_full && !pop;

    assign out_if.out_valid = !fifo_empty;
    assign {out_if.out_last, out_if.out_addr, out_if.out_data} = mem_q[rd_ptr_q[PTR_W-2:0]];

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (capture && last_beat) state_d = S_DRAIN;
            S_DRAIN: if (!stg_valid_q && fifo_empty) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy       = (state_q != S_IDLE);
        frame_done = (state_q == S_DONE);
        state_o    = state_q;
    end

    // Datapath next state. addr_cnt advances on every captured beat, even
    // if that beat is later dropped, so subsequent addresses stay aligned.
    always_comb begin
        addr_cnt_d       = addr_cnt_q;
        overflow_d       = overflow_q;
        protocol_error_d = protocol_error_q;
        stg_valid_d      = capture;
        stg_data_d       = stg_data_q;
        stg_addr_d       = stg_addr_q;
        stg_last_d       = stg_last_q;
        wr_ptr_d         = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d         = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        if (start_accept) begin
            addr_cnt_d       = '0;
            overflow_d       = 1'b0;
            protocol_error_d = 1'b0;
        end
        if (capture) begin
            addr_cnt_d = addr_cnt_q + ADDR_W'(1);
            stg_data_d = scaled;
            stg_addr_d = addr_cnt_q;
            stg_last_d = last_beat;
        end
        if (drop) begin
            overflow_d = 1'b1;
        end
        if (in_valid && (state_q != S_RUN)) begin
            protocol_error_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_cnt_q       <= '0;
            overflow_q       <= 1'b0;
            protocol_error_q <= 1'b0;
            stg_valid_q      <= 1'b0;
            stg_data_q       <= '0;
            stg_addr_q       <= '0;
            stg_last_q       <= 1'b0;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            addr_cnt_q       <= addr_cnt_d;
            overflow_q       <= overflow_d;
            protocol_error_q <= protocol_error_d;
            stg_valid_q      <= stg_valid_d;
            stg_data_q       <= stg_data_d;
            stg_addr_q       <= stg_addr_d;
            stg_last_q       <= stg_last_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            if (push) begin
                mem_q[wr_ptr_q[PTR_W-2:0]] <= {stg_last_q, stg_addr_q, stg_data_q};
            end
        end
    end

    assign overflow       = overflow_q;
    assign protocol_error = protocol_error_q;
endmodule

// File: tb/tb_conv_output_collector.sv
// ---------------------------------------------------------------------------
// tb_conv_output_collector
//   Directed sequence with randomized sample values. Expected output entries
//   ({last, addr, data}) are queued when a beat is driven; a negedge monitor
//   pops and compares every accepted output and checks hold-while-stalled.
// ---------------------------------------------------------------------------
module tb_conv_output_collector;
    localparam int DATA_WIDTH  = 16;
    localparam int ACC_WIDTH   = 40;
    localparam int FRAC_BITS   = 8;
    localparam int IMAGE_SIZE  = 28;
    localparam int KERNEL_SIZE = 5;
    localparam int FIFO_DEPTH  = 4;
    localparam int OUT_DIM     = IMAGE_SIZE - KERNEL_SIZE + 1;
    localparam int NPIX        = OUT_DIM * OUT_DIM;
    localparam int ADDR_W      = $clog2(NPIX);
    localparam int W           = 1 + ADDR_W + DATA_WIDTH;

`ifdef CONV_RELU_EN
    localparam logic [DATA_WIDTH-1:0] EXP_NEG_BIG = 16'h0000;
    localparam logic [DATA_WIDTH-1:0] EXP_NEG_ONE = 16'h0000;
`else
    localparam logic [DATA_WIDTH-1:0] EXP_NEG_BIG = 16'h8000;
    localparam logic [DATA_WIDTH-1:0] EXP_NEG_ONE = 16'hFFFF;
`endif

    // ---------------- clock / reset ----------------
    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic                 in_valid;
    logic [ACC_WIDTH-1:0] in_data;
    logic                 busy, frame_done, overflow, protocol_error;
    logic [1:0]           state_dbg;

    always #5 clk = ~clk;

    conv_output_collector_if #(.DATA_WIDTH(DATA_WIDTH), .ADDR_W(ADDR_W)) out_if ();

    conv_output_collector #(
        .DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH), .FRAC_BITS(FRAC_BITS),
        .IMAGE_SIZE(IMAGE_SIZE), .KERNEL_SIZE(KERNEL_SIZE), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .out_if         (out_if),
        .busy           (busy),
        .frame_done     (frame_done),
        .overflow       (overflow),
        .protocol_error (protocol_error),
        .state_o        (state_dbg)
    );

    // ---------------- scoreboard state ----------------
    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int fd_count    = 0;
    int fd_cyc      = 0;
    int last_pop_cyc = 0;
    int beat_idx    = 0;
    logic [W-1:0] exp_q[$];
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_head  = '0;
    logic [W-1:0] mon_head, mon_exp;
    longint       dir_val [7];
    logic [ACC_WIDTH-1:0] d;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [DATA_WIDTH-1:0] ref_scale(input logic [ACC_WIDTH-1:0] raw);
        longint x, dv, q, hi, lo;
        x  = longint'($signed(raw));
        dv = longint'(1) << FRAC_BITS;
        q  = x / dv;
        if ((x % dv) != 0 && x < 0) q = q - 1;   // floor toward -inf
`ifdef CONV_RELU_EN
        if (q < 0) q = 0;
`endif
        hi = (longint'(1) << (DATA_WIDTH - 1)) - 1;
        lo = -(longint'(1) << (DATA_WIDTH - 1));
        if (q > hi) q = hi;
        else if (q < lo) q = lo;
        return q[DATA_WIDTH-1:0];
    endfunction

    function automatic logic [ACC_WIDTH-1:0] rand_acc();
        logic [63:0] t;
        longint v;
        case ($urandom_range(0, 2))
            0: v = longint'($urandom_range(0, 131071)) - 65536;
            1: v = longint'($urandom_range(0, 33554431)) - 16777216;
            default: begin
                t = {$urandom(), $urandom()};
                v = longint'(t);
            end
        endcase
        return v[ACC_WIDTH-1:0];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_frame();
        fd_count = 0;
        beat_idx = 0;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [ACC_WIDTH-1:0] v,
                             input logic [DATA_WIDTH-1:0] exp_data, input bit keep);
        in_valid = 1'b1;
        in_data  = v;
        if (keep) exp_q.push_back({(beat_idx == NPIX - 1), ADDR_W'(beat_idx), exp_data});
        beat_idx++;
        step();
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic wait_frame_end();
        for (int i = 0; i < 200 && busy; i++) step();
        check("frame_end_busy", busy, 0);
        check("frame_done_count", fd_count, 1);
        check("frame_done_delay", fd_cyc - last_pop_cyc, 2);
        check("frame_overflow", overflow, 0);
        check("frame_exp_left", exp_q.size(), 0);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) step();
        check(tag, exp_q.size(), 0);
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            mon_head = {out_if.out_last, out_if.out_addr, out_if.out_data};
            if (frame_done) begin
                fd_count++;
                fd_cyc = cyc;
            end
            if (prev_stall) begin
                check("hold_valid", out_if.out_valid, 1);
                check("hold_head", mon_head, prev_head);
            end
            if (out_if.out_valid && out_if.out_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $error("FAIL unexpected_out: observed addr %0d data %0h, expected no output",
                           out_if.out_addr, out_if.out_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("out_addr", out_if.out_addr, mon_exp[DATA_WIDTH +: ADDR_W]);
                    check("out_data", out_if.out_data, mon_exp[DATA_WIDTH-1:0]);
                    check("out_last", out_if.out_last, mon_exp[W-1]);
                    if (out_if.out_last) last_pop_cyc = cyc;
                end
            end
            prev_stall = out_if.out_valid && !out_if.out_ready;
            prev_head  = mon_head;
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_if.out_ready = 1'b1;
        dir_val[0] = longint'(1) << 30;
        dir_val[1] = -(longint'(1) << 30);
        dir_val[2] = -1;
        dir_val[3] = 32767 * 256 + 255;
        dir_val[4] = 32768 * 256;
        dir_val[5] = -32768 * 256;
        dir_val[6] = -32768 * 256 - 1;

        // Reset values
        repeat (3) step();
        check("rst_out_valid", out_if.out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_overflow", overflow, 0);
        check("rst_protocol_error", protocol_error, 0);
        rst = 1'b0;
        step();

        // Contiguous frame: in_data = k<<8 gives data k at address k
        begin_frame();
        check("contig_busy", busy, 1);
        for (int k = 0; k < NPIX; k++) begin
            send_beat(ACC_WIDTH'(k) << FRAC_BITS, DATA_WIDTH'(k), 1'b1);
        end
        wait_frame_end();

        // Gapped frame with saturation cases and random data
        begin_frame();
        idle(25);
        for (int r = 0; r < OUT_DIM; r++) begin
            for (int c = 0; c < OUT_DIM; c++) begin
                if (r == 0 && c < 7) begin
                    d = dir_val[c][ACC_WIDTH-1:0];
                    if (c == 0)      send_beat(d, 16'h7FFF, 1'b1);
                    else if (c == 1) send_beat(d, EXP_NEG_BIG, 1'b1);
                    else if (c == 2) send_beat(d, EXP_NEG_ONE, 1'b1);
                    else             send_beat(d, ref_scale(d), 1'b1);
                end else begin
                    d = rand_acc();
                    send_beat(d, ref_scale(d), 1'b1);
                end
            end
            idle(4);
        end
        wait_frame_end();

        // Backpressure: 6 beats into a 4-deep FIFO with no reads
        begin_frame();
        out_if.out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            d = rand_acc();
            send_beat(d, ref_scale(d), k < 4);
        end
        idle(3);
        check("bp_overflow", overflow, 1);
        check("bp_out_valid", out_if.out_valid, 1);
        check("bp_head_addr", out_if.out_addr, 0);
        out_if.out_ready = 1'b1;
        wait_drain("bp_drain");
        for (int k = 6; k < 100; k++) begin
            d = rand_acc();
            send_beat(d, ref_scale(d), 1'b1);
        end

        // Mid-frame reset at beat 100
        in_valid = 1'b1;
        in_data  = rand_acc();
        rst = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        check("mfr_out_valid", out_if.out_valid, 0);
        check("mfr_busy", busy, 0);
        check("mfr_overflow", overflow, 0);
        step();
        check("mfr_out_valid_2", out_if.out_valid, 0);

        // Protocol error in IDLE, then cleared by start
        in_valid = 1'b1;
        in_data  = rand_acc();
        step();
        in_valid = 1'b0;
        check("perr_set", protocol_error, 1);
        step();
        step();
        check("perr_no_out", out_if.out_valid, 0);
        check("perr_busy", busy, 0);
        begin_frame();
        check("perr_cleared", protocol_error, 0);
        check("perr_start_busy", busy, 1);
        d = rand_acc();
        send_beat(d, ref_scale(d), 1'b1);
        wait_drain("restart_addr0");
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
